// File: rtl/generation_sequencer_pkg.sv
// Shared types and sizing helpers for the Conway generation sequencer.
package conway_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WRITE,
        S_COMMIT
    } seq_state_t;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/generation_sequencer_if.sv
// Host/datapath control bundle of the generation sequencer; master drives the
// host pulses, slave (the sequencer) drives the board strobes and status.
interface generation_sequencer_if
    import conway_ctrl_pkg::*;
#(
    parameter int ROWS  = 11,
    parameter int GEN_W = 16
);
    localparam int ROW_W = row_w(ROWS);

    logic             start;
    logic             step;
    logic             stop;
    logic             load_req;
    logic             load_grant;
    logic [ROW_W-1:0] row_sel;
    logic             calc_we;
    logic             commit_we;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             done;

    modport master (
        output start, step, stop, load_req,
        input  load_grant, row_sel, calc_we, commit_we, gen_count, busy, done
    );

    modport slave (
        input  start, step, stop, load_req,
        output load_grant, row_sel, calc_we, commit_we, gen_count, busy, done
    );

endinterface

// File: rtl/generation_sequencer_row_counter.sv
// Row index for the generation sweep: clear has priority over increment,
// last_o flags the final board row.
module row_counter #(
    parameter int ROWS  = 11,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;

    always_comb begin
        row_d = row_q;
        if (clr_i) begin
            row_d = '0;
        end else if (inc_i) begin
            row_d = row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_o  = row_q;
    assign last_o = (row_q == ROW_W'(ROWS - 1));

endmodule

// File: rtl/generation_sequencer.sv
// Sequences one Conway generation row by row, then commits next -> current;
// arbitrates board access between host loading and stepping, counts generations.
module generation_sequencer
    import conway_ctrl_pkg::*;
#(
    parameter int ROWS     = 11,
    parameter int GEN_W    = 16,
    parameter int CALC_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    generation_sequencer_if.slave bus_if
);
    localparam int ROW_W = row_w(ROWS);
    localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

    seq_state_t       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             run_q, run_d;
    logic             stop_pend_q, stop_pend_d;
    logic [GEN_W-1:0] gen_q;
    logic             row_inc, row_clr, row_last;
    logic             gen_inc, gen_clr;
    logic [ROW_W-1:0] row_idx;

    row_counter #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_row_counter (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (row_inc),
        .clr_i  (row_clr),
        .row_o  (row_idx),
        .last_o (row_last)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        run_d       = run_q;
        stop_pend_d = stop_pend_q;
        row_inc     = 1'b0;
        row_clr     = 1'b0;
        gen_inc     = 1'b0;
        gen_clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                run_d       = 1'b0;
                stop_pend_d = 1'b0;
                if (bus_if.load_req) begin
                    state_d = S_LOAD;
                end else if (bus_if.step) begin
                    state_d = S_CALC;
                end else if (bus_if.start) begin
                    state_d = S_CALC;
                    run_d   = 1'b1;
                end
            end
            S_LOAD: begin
                if (!bus_if.load_req) begin
                    state_d = S_IDLE;
                    gen_clr = 1'b1;
                end
            end
            S_CALC: begin
                if (lat_q == LAT_W'(CALC_LAT - 1)) begin
                    lat_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE: begin
                if (row_last) begin
                    row_clr = 1'b1;
                    state_d = S_COMMIT;
                end else begin
                    row_inc = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_COMMIT: begin
                gen_inc = 1'b1;
                // A pending load request ends a continuous run just like stop.
                if (run_q && !stop_pend_q && !bus_if.stop && !bus_if.load_req) begin
                    state_d = S_CALC;
                end else begin
                    state_d     = S_IDLE;
                    run_d       = 1'b0;
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_q == S_CALC || state_q == S_WRITE) && bus_if.stop) begin
            stop_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            run_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            gen_q       <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            run_q       <= run_d;
            stop_pend_q <= stop_pend_d;
            if (gen_clr) begin
                gen_q <= '0;
            end else if (gen_inc) begin
                gen_q <= gen_q + GEN_W'(1);
            end
        end
    end

    // Strobes decode straight from state so reset silences them immediately.
    assign bus_if.load_grant = (state_q == S_LOAD);
    assign bus_if.calc_we    = (state_q == S_WRITE);
    assign bus_if.commit_we  = (state_q == S_COMMIT);
    assign bus_if.done       = (state_q == S_COMMIT);
    assign bus_if.busy       = (state_q == S_CALC) || (state_q == S_WRITE) ||
                               (state_q == S_COMMIT);
    assign bus_if.row_sel    = row_idx;
    assign bus_if.gen_count  = gen_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed bench for generation_sequencer: scoreboard of expected row writes,
// commit cycles and generation counts, checked by a negedge monitor.
module tb_generation_sequencer;
    import conway_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   c0  = 0;
    int   total = 0;
    int   bad   = 0;
    int   exp_gen = 0;
    int   row_q[$];
    int   com_q[$];
    int   gen_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generation_sequencer_if #(.ROWS(11), .GEN_W(16)) ifa ();
    generation_sequencer_if #(.ROWS(11), .GEN_W(2))  ifb ();

    generation_sequencer #(.ROWS(11), .GEN_W(16), .CALC_LAT(1)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ifa.slave)
    );

    generation_sequencer #(.ROWS(11), .GEN_W(2), .CALC_LAT(1)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_if (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_gen(input int rel);
        for (int r = 0; r < 11; r++) row_q.push_back(r);
        com_q.push_back(rel);
        gen_q.push_back(exp_gen);
        exp_gen++;
    endtask

    // Drive a one-cycle pulse; when mark is set the sampling edge becomes edge 0.
    task automatic pulse(input bit sel_b, input logic s, input logic st,
                         input logic sp, input bit mark);
        @(negedge clk);
        if (sel_b) begin ifb.step = s; ifb.start = st; ifb.stop = sp; end
        else       begin ifa.step = s; ifa.start = st; ifa.stop = sp; end
        @(posedge clk);
        #1;
        if (mark) c0 = cyc;
        @(negedge clk);
        ifa.step = 1'b0; ifa.start = 1'b0; ifa.stop = 1'b0;
        ifb.step = 1'b0; ifb.start = 1'b0; ifb.stop = 1'b0;
    endtask

    task automatic wait_idle(input bit sel_b, input int budget);
        int n = 0;
        @(negedge clk);
        while ((sel_b ? ifb.busy : ifa.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", sel_b ? ifb.busy : ifa.busy, 0);
    endtask

    task automatic wait_done_b(input int budget);
        int n = 0;
        while (!ifb.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_b_timeout", ifb.done, 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},       ifa.busy,       0);
        chk({tag, "_calc_we"},    ifa.calc_we,    0);
        chk({tag, "_commit_we"},  ifa.commit_we,  0);
        chk({tag, "_done"},       ifa.done,       0);
        chk({tag, "_load_grant"}, ifa.load_grant, 0);
        chk({tag, "_row_sel"},    ifa.row_sel,    0);
        chk({tag, "_gen_count"},  ifa.gen_count,  0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ifa.calc_we) begin
                chk("calc_commit_overlap", ifa.commit_we, 0);
                chk("calc_we_expected", (row_q.size() > 0) ? 1 : 0, 1);
                if (row_q.size() > 0) chk("row_sel", ifa.row_sel, row_q.pop_front());
            end
            if (ifa.commit_we) begin
                chk("done_with_commit", ifa.done, 1);
                chk("commit_expected", (com_q.size() > 0) ? 1 : 0, 1);
                if (com_q.size() > 0) begin
                    chk("commit_cycle", cyc - c0 + 1, com_q.pop_front());
                    chk("gen_before_commit", ifa.gen_count, gen_q.pop_front());
                end
            end
            if (ifa.load_grant) begin
                chk("we_in_load", {ifa.calc_we, ifa.commit_we}, 0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        ifa.start = 1'b0; ifa.step = 1'b0; ifa.stop = 1'b0; ifa.load_req = 1'b0;
        ifb.start = 1'b0; ifb.step = 1'b0; ifb.stop = 1'b0; ifb.load_req = 1'b0;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Single step: 11 row writes, commit in cycle 23, count 1 afterwards.
        push_gen(23);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("step_busy", ifa.busy, 1);
        wait_idle(1'b0, 100);
        chk("step_gen", ifa.gen_count, 1);
        chk("step_rows_left", row_q.size(), 0);

        // Continuous run halted by stop during the second generation.
        push_gen(23);
        push_gen(46);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (27) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_idle(1'b0, 100);
        chk("run_stop_gen", ifa.gen_count, 3);
        repeat (20) @(negedge clk);
        chk("run_stop_idle", ifa.busy, 0);
        chk("run_stop_commits_left", com_q.size(), 0);

        // step and start together: one generation only.
        push_gen(23);
        pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle(1'b0, 100);
        repeat (30) @(negedge clk);
        chk("step_start_gen", ifa.gen_count, 4);
        chk("step_start_idle", ifa.busy, 0);
        chk("step_start_commits_left", com_q.size(), 0);

        // Load request during a step is granted only after the commit.
        push_gen(23);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        ifa.load_req = 1'b1;
        for (int n = 0; n < 100 && ifa.busy; n++) begin
            chk("grant_while_busy", ifa.load_grant, 0);
            @(negedge clk);
        end
        chk("load_wait_timeout", ifa.busy, 0);
        @(negedge clk);
        chk("grant_after_commit", ifa.load_grant, 1);
        chk("load_gen_before_clear", ifa.gen_count, 5);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("grant_held", ifa.load_grant, 1);
        chk("step_in_load_busy", ifa.busy, 0);
        ifa.load_req = 1'b0;
        @(negedge clk);
        chk("grant_released", ifa.load_grant, 0);
        chk("load_gen_cleared", ifa.gen_count, 0);
        exp_gen = 0;

        // Reset mid-run silences every output within the cycle.
        push_gen(23);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", ifa.busy, 1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("mid_reset");
        row_q.delete();
        com_q.delete();
        gen_q.delete();
        exp_gen = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_reset_idle", ifa.busy, 0);
        chk("post_reset_row", ifa.row_sel, 0);

        // Two-bit counter wraps 1,2,3,0 over four run-mode generations.
        pulse(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int g = 1; g <= 4; g++) begin
            wait_done_b(60);
            @(negedge clk);
            chk("wrap_gen", ifb.gen_count, g % 4);
            if (g == 3) pulse(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        wait_idle(1'b1, 60);
        repeat (30) @(negedge clk);
        chk("wrap_idle", ifb.busy, 0);
        chk("wrap_final", ifb.gen_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
